// File: rtl/cam_pkg.sv
// Shared types and constants for the camera stream decoder.
package cam_pkg;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SYNC      = 2'd1,
    LINE_WAIT = 2'd2,
    ACTIVE    = 2'd3
  } cam_state_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned X_WIDTH_DEF  = 10;
  localparam int unsigned Y_WIDTH_DEF  = 9;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned PIXEL_W      = 16;

  // First byte of a pair lands in the upper half of the pixel.
  localparam bit MSB_FIRST = 1'b1;

  function automatic logic [PIXEL_W-1:0] pack_pair(input logic [BYTE_W-1:0] first,
                                                   input logic [BYTE_W-1:0] second);
    return MSB_FIRST ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Pairs consecutive camera bytes into one registered pixel with a one-cycle valid strobe.
module byte_packer
  import cam_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               emit_i,
  input  logic [BYTE_W-1:0]  din_i,
  output logic               phase_o,
  output logic [PIXEL_W-1:0] pixel_o,
  output logic               pixel_valid_o
);

  logic               phase_q;
  logic [BYTE_W-1:0]  hi_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               valid_q;

  // Pixel holds its value between strobes; emit_i suppresses out-of-window pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear_i) begin
        phase_q <= 1'b0;
      end else if (enable_i) begin
        if (!phase_q) begin
          hi_q <= din_i;
        end else if (emit_i) begin
          pixel_q <= pack_pair(hi_q, din_i);
          valid_q <= 1'b1;
        end
        phase_q <= ~phase_q;
      end
    end
  end

  assign phase_o       = phase_q;
  assign pixel_o       = pixel_q;
  assign pixel_valid_o = valid_q;

endmodule

// File: rtl/cam_stream_decoder.sv
// Camera receive decoder: frame/line tracking, pixel position recovery and error flags.
module cam_stream_decoder
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned X_WIDTH  = X_WIDTH_DEF,
  parameter int unsigned Y_WIDTH  = Y_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         din,
  output logic [15:0]        pixel,
  output logic               pixel_valid,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               frame_start,
  output logic               frame_end,
  output logic               frame_parity,
  output logic               line_error,
  output logic               frame_error
);

  localparam int unsigned       CW       = $clog2(H_ACTIVE + 1);
  localparam logic [CW-1:0]      COL_FULL = CW'(H_ACTIVE);
  localparam logic [Y_WIDTH-1:0] ROW_FULL = Y_WIDTH'(V_ACTIVE);
  localparam logic [Y_WIDTH-1:0] ROW_MAX  = '1;

  cam_state_e         state_q;
  logic [CW-1:0]      col_q;
  logic               col_ovf_q;
  logic [Y_WIDTH-1:0] row_q;
  logic [X_WIDTH-1:0] x_q;
  logic [Y_WIDTH-1:0] y_q;
  logic               frame_start_q;
  logic               frame_end_q;
  logic               frame_parity_q;
  logic               line_error_q;
  logic               frame_error_q;

  logic               phase;
  logic               start_line_c;
  logic               byte_c;
  logic               line_end_c;
  logic               abort_c;
  logic               emit_c;
  logic               line_bad_c;
  logic [Y_WIDTH-1:0] row_inc_c;

  // vsync takes priority over href in every state.
  assign start_line_c = (state_q == LINE_WAIT) && !vsync && href;
  assign byte_c       = (state_q == ACTIVE) && !vsync && href;
  assign line_end_c   = (state_q == ACTIVE) && !vsync && !href;
  assign abort_c      = (state_q == ACTIVE) && vsync;
  assign emit_c       = (col_q < COL_FULL) && (row_q < ROW_FULL);
  assign line_bad_c   = phase || col_ovf_q || (col_q != COL_FULL);
  assign row_inc_c    = (row_q == ROW_MAX) ? row_q : row_q + Y_WIDTH'(1);

  byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (line_end_c || abort_c),
    .enable_i      (start_line_c || byte_c),
    .emit_i        (emit_c),
    .din_i         (din),
    .phase_o       (phase),
    .pixel_o       (pixel),
    .pixel_valid_o (pixel_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HUNT;
      col_q          <= '0;
      col_ovf_q      <= 1'b0;
      row_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_parity_q <= 1'b0;
      line_error_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      case (state_q)
        HUNT: begin
          if (vsync) state_q <= SYNC;
        end
        SYNC: begin
          if (!vsync) begin
            state_q       <= LINE_WAIT;
            frame_start_q <= 1'b1;
            row_q         <= '0;
          end
        end
        LINE_WAIT: begin
          if (vsync) begin
            state_q        <= SYNC;
            frame_end_q    <= 1'b1;
            frame_parity_q <= ~frame_parity_q;
            if (row_q != ROW_FULL) frame_error_q <= 1'b1;
          end else if (href) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vsync || !href) begin
            // Line closes either normally or by a vsync abort; both run the line checks.
            if (line_bad_c) line_error_q <= 1'b1;
            row_q     <= row_inc_c;
            col_q     <= '0;
            col_ovf_q <= 1'b0;
            if (vsync) begin
              state_q        <= SYNC;
              frame_end_q    <= 1'b1;
              frame_parity_q <= ~frame_parity_q;
              if (row_inc_c != ROW_FULL) frame_error_q <= 1'b1;
            end else begin
              state_q <= LINE_WAIT;
            end
          end else if (phase) begin
            if (emit_c) begin
              x_q <= X_WIDTH'(col_q);
              y_q <= row_q;
            end
            // Saturate at H_ACTIVE but remember that the line ran long.
            if (col_q == COL_FULL) col_ovf_q <= 1'b1;
            else                   col_q     <= col_q + CW'(1);
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign frame_parity = frame_parity_q;
  assign line_error   = line_error_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_cam_stream_decoder.sv
// Randomised bench for cam_stream_decoder against a frame/line-level reference model.
module tb_cam_stream_decoder;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = 10;
  localparam int YW = 9;

  typedef struct packed {
    logic [15:0]   pix;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          href;
  logic [7:0]    din;
  logic [15:0]   pixel;
  logic          pixel_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;
  logic          frame_end;
  logic          frame_parity;
  logic          line_error;
  logic          frame_error;

  int checks = 0;
  int errors = 0;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   fs_cnt, fe_cnt, pv_double;
  bit   prev_pv;

  int m_row, m_fs, m_fe;
  bit m_line_err, m_frame_err, m_parity;

  cam_stream_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .din(din),
    .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .frame_end(frame_end), .frame_parity(frame_parity),
    .line_error(line_error), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Capture every strobe and pulse seen on the outputs.
  always @(negedge clk) begin
    if (reset) begin
      prev_pv = 1'b0;
    end else begin
      if (pixel_valid) begin
        got_q.push_back({pixel, x, y});
        if (prev_pv) pv_double++;
      end
      if (frame_start) fs_cnt++;
      if (frame_end) fe_cnt++;
      prev_pv = pixel_valid;
    end
  end

  task automatic drive(input bit v, input bit h, input logic [7:0] d);
    vsync = v; href = h; din = d;
    @(negedge clk);
  endtask

  task automatic clear_model();
    got_q.delete(); exp_q.delete();
    fs_cnt = 0; fe_cnt = 0; pv_double = 0;
    m_row = 0; m_fs = 0; m_fe = 0;
    m_line_err = 0; m_frame_err = 0; m_parity = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic model_frame_end();
    if (m_row != V) m_frame_err = 1'b1;
    m_parity = ~m_parity;
    m_fe++;
  endtask

  // Reference: a line of n bytes yields n/2 pixels, only those inside the HxV window strobe.
  task automatic model_line(input logic [7:0] b[$], input bit abort);
    int np;
    np = b.size() / 2;
    for (int p = 0; p < np; p++)
      if (p < H && m_row < V)
        exp_q.push_back({b[2*p], b[2*p+1], XW'(p), YW'(m_row)});
    if ((b.size() % 2) != 0 || np != H) m_line_err = 1'b1;
    m_row++;
    if (abort) model_frame_end();
  endtask

  task automatic start_frame(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    m_row = 0;
    m_fs++;
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 8'($urandom));
    model_frame_end();
  endtask

  task automatic send_line(input int len, input bit ramp, input int gap);
    logic [7:0] b[$];
    for (int i = 0; i < len; i++) b.push_back(ramp ? 8'(i) : 8'($urandom));
    for (int i = 0; i < len; i++) drive(1'b0, 1'b1, b[i]);
    model_line(b, 1'b0);
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_abort(input int len);
    logic [7:0] b[$];
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    for (int i = 0; i < len; i++) drive(1'b0, 1'b1, b[i]);
    drive(1'b1, 1'b0, 8'($urandom));
    model_line(b, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; href = 1'b1; din = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({pixel, pixel_valid, x, y, frame_start, frame_end, frame_parity, line_error, frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pixel=%h pv=%b x=%0d y=%0d fs=%b fe=%b par=%b le=%b ferr=%b, expected all 0",
               pixel, pixel_valid, x, y, frame_start, frame_end, frame_parity, line_error, frame_error);
    end
    do_reset();
  endtask

  task automatic test_clean_frame();
    logic [7:0] b[$];
    do_reset();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    m_fs++; m_row = 0;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL clean_frame_start: got %b expected 1", frame_start); end
    for (int i = 0; i < 8; i++) begin
      b.push_back(8'(i));
      drive(1'b0, 1'b1, 8'(i));
      if (i == 1) begin
        checks++;
        if (pixel_valid !== 1'b1 || pixel !== 16'h0001 || x !== '0 || y !== '0) begin
          errors++;
          $display("FAIL clean_latency: got pv=%b pixel=%h x=%0d y=%0d expected pv=1 pixel=0001 x=0 y=0", pixel_valid, pixel, x, y);
        end
      end
      if (i == 2) begin
        checks++;
        if (pixel_valid !== 1'b0 || pixel !== 16'h0001) begin
          errors++;
          $display("FAIL clean_strobe_width: got pv=%b pixel=%h expected pv=0 pixel=0001", pixel_valid, pixel);
        end
      end
    end
    model_line(b, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    send_line(8, 1'b1, 1);
    send_line(8, 1'b1, 1);
    end_frame();
    checks++;
    if (frame_end !== 1'b1 || frame_parity !== 1'b1 || line_error !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL clean_frame_end: got fe=%b par=%b le=%b ferr=%b expected 1 1 0 0", frame_end, frame_parity, line_error, frame_error);
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != 12 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clean_pixel_count: got %0d expected 12", got_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clean_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fs_cnt != m_fs || fe_cnt != m_fe || pv_double != 0) begin
      errors++; $display("FAIL clean_pulses: got fs=%0d fe=%0d dbl=%0d expected %0d %0d 0", fs_cnt, fe_cnt, pv_double, m_fs, m_fe);
    end
  endtask

  task automatic test_odd_line();
    do_reset();
    start_frame(2);
    send_line(8, 1'b0, 1);
    checks++;
    if (line_error !== 1'b0) begin errors++; $display("FAIL odd_before: got line_error=%b expected 0", line_error); end
    send_line(7, 1'b0, 1);
    checks++;
    if (line_error !== 1'b1) begin errors++; $display("FAIL odd_line_error: got %b expected 1", line_error); end
    send_line(8, 1'b0, 2);
    end_frame();
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 11) begin
      errors++; $display("FAIL odd_pixel_count: got %0d expected 11", got_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({line_error, frame_error, frame_parity} !== {m_line_err, m_frame_err, m_parity}) begin
      errors++; $display("FAIL odd_flags: got le/ferr/par=%b%b%b expected %b%b%b", line_error, frame_error, frame_parity, m_line_err, m_frame_err, m_parity);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    start_frame(3);
    send_line(8, 1'b0, 1);
    send_line(8, 1'b0, 1);
    end_frame();
    checks++;
    if (frame_end !== 1'b1 || frame_error !== 1'b1 || line_error !== 1'b0 || frame_parity !== 1'b1) begin
      errors++; $display("FAIL short_frame: got fe=%b ferr=%b le=%b par=%b expected 1 1 0 1", frame_end, frame_error, line_error, frame_parity);
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL short_pixel_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_long();
    do_reset();
    start_frame(1);
    send_line(10, 1'b0, 1);
    checks++;
    if (line_error !== 1'b1) begin errors++; $display("FAIL long_line_error: got %b expected 1", line_error); end
    for (int l = 0; l < 3; l++) send_line(8, 1'b0, 1);
    end_frame();
    checks++;
    if (frame_error !== 1'b1 || frame_end !== 1'b1) begin
      errors++; $display("FAIL long_frame: got ferr=%b fe=%b expected 1 1", frame_error, frame_end);
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 12) begin
      errors++; $display("FAIL long_pixel_count: got %0d expected 12", got_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_midline_vsync();
    do_reset();
    start_frame(2);
    send_abort(3);
    checks++;
    if (frame_end !== 1'b1 || line_error !== 1'b1 || frame_error !== 1'b1 || frame_parity !== 1'b1) begin
      errors++; $display("FAIL abort_flags: got fe=%b le=%b ferr=%b par=%b expected 1 1 1 1", frame_end, line_error, frame_error, frame_parity);
    end
    start_frame(1);
    for (int l = 0; l < 3; l++) send_line(8, 1'b0, 1);
    end_frame();
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 13) begin
      errors++; $display("FAIL abort_pixel_count: got %0d expected 13", got_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (fe_cnt != m_fe || fs_cnt != m_fs || frame_parity !== m_parity) begin
      errors++; $display("FAIL abort_pulses: got fs=%0d fe=%0d par=%b expected %0d %0d %b", fs_cnt, fe_cnt, frame_parity, m_fs, m_fe, m_parity);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    start_frame(1);
    send_line(8, 1'b0, 1);
    end_frame();
    start_frame(1);
    drive(1'b0, 1'b1, 8'hA5);
    drive(1'b0, 1'b1, 8'h5A);
    drive(1'b0, 1'b1, 8'h33);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pixel, pixel_valid, x, y, frame_start, frame_end, frame_parity, line_error, frame_error} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pixel=%h pv=%b x=%0d y=%0d fs=%b fe=%b par=%b le=%b ferr=%b expected all 0",
               pixel, pixel_valid, x, y, frame_start, frame_end, frame_parity, line_error, frame_error);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'($urandom));
      drive(1'b0, 1'b0, 8'h00);
    end
    checks++;
    if (got_q.size() != 0 || fs_cnt != 0) begin
      errors++; $display("FAIL hunt_ignores_href: got strobes=%0d fs=%0d expected 0 0", got_q.size(), fs_cnt);
    end
    start_frame(2);
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL resync_frame_start: got %b expected 1", frame_start); end
    for (int l = 0; l < 3; l++) send_line(8, 1'b0, 1);
    end_frame();
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 12) begin
      errors++; $display("FAIL resync_pixel_count: got %0d expected 12", got_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL resync_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({line_error, frame_error, frame_parity} !== {m_line_err, m_frame_err, m_parity}) begin
      errors++; $display("FAIL resync_flags: got le/ferr/par=%b%b%b expected %b%b%b", line_error, frame_error, frame_parity, m_line_err, m_frame_err, m_parity);
    end
  endtask

  task automatic test_random_frames();
    int nl, len;
    bit aborted;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      start_frame($urandom_range(1, 3));
      nl = $urandom_range(2, 4);
      aborted = 1'b0;
      for (int l = 0; l < nl; l++) begin
        case ($urandom_range(0, 9))
          6: len = 6;
          7: len = 7;
          8: len = 9;
          9: len = 10;
          default: len = 8;
        endcase
        if (l == nl - 1 && $urandom_range(0, 3) == 0) begin
          send_abort($urandom_range(1, 9));
          aborted = 1'b1;
        end else begin
          send_line(len, 1'b0, $urandom_range(1, 3));
        end
      end
      if (!aborted) end_frame();
    end
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_pixel_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({line_error, frame_error, frame_parity} !== {m_line_err, m_frame_err, m_parity}) begin
      errors++; $display("FAIL rand_flags: got le/ferr/par=%b%b%b expected %b%b%b", line_error, frame_error, frame_parity, m_line_err, m_frame_err, m_parity);
    end
    checks++;
    if (fs_cnt != m_fs || fe_cnt != m_fe || pv_double != 0) begin
      errors++; $display("FAIL rand_pulses: got fs=%0d fe=%0d dbl=%0d expected %0d %0d 0", fs_cnt, fe_cnt, pv_double, m_fs, m_fe);
    end
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    clear_model();
    test_reset();
    test_clean_frame();
    test_odd_line();
    test_short_frame();
    test_long();
    test_midline_vsync();
    test_reset_midframe();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_decoder.md
# cam_stream_decoder

Receive-side timing decoder for the camera byte stream feeding the stereo encryption path. Samples vsync/href/8-bit data on the pixel clock and packs byte pairs into 16-bit pixels. Recovers x/y position and frame boundaries, then flags malformed lines and frames. Downstream keystream/cipher logic consumes pixel_valid, x and y; it does not run free-running counters of its own.

## Interface
- H_ACTIVE, 640: expected pixels per line.
- V_ACTIVE, 480: expected lines per frame.
- X_WIDTH, 10: width of x; must hold H_ACTIVE-1.
- Y_WIDTH, 9: width of y; must hold V_ACTIVE-1.
- clk  in  1  pixel clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high.
- vsync  in  1  frame sync; high = vertical blanking.
- href  in  1  line valid; high = active bytes on din.
- din  in  8  camera byte; the first byte of a pair is the MSB.
- pixel  out  16  assembled pixel {first byte, second byte}.
- pixel_valid  out  1  one-cycle strobe qualifying pixel, x and y.
- x  out  X_WIDTH  column of the current pixel, 0..H_ACTIVE-1.
- y  out  Y_WIDTH  row of the current pixel, 0..V_ACTIVE-1.
- frame_start  out  1  one-cycle pulse at the start of an active frame.
- frame_end  out  1  one-cycle pulse at the end of a frame.
- frame_parity  out  1  toggles on each frame_end; 0 = left eye, 1 = right eye.
- line_error  out  1  sticky; a line had an odd byte count or a pixel count other than H_ACTIVE.
- frame_error  out  1  sticky; a frame had a line count other than V_ACTIVE.

## Operation
- **Reset values:** all outputs 0; state HUNT; byte phase 0; internal line and pixel counters 0.
- **HUNT:** ignore href and din. On a sampled vsync=1, go to SYNC. Any reset therefore discards the rest of the current frame.
- **SYNC:** on a sampled vsync=0, go to LINE_WAIT, pulse frame_start, clear the row counter.
- **LINE_WAIT:**
  - href=1: go to ACTIVE. The byte sampled on that edge is the first byte of pixel 0.
  - vsync=1: pulse frame_end, toggle frame_parity, go to SYNC. If completed lines ≠ V_ACTIVE, set frame_error.
- **ACTIVE:**
  - Each sampled byte alternates phase. Phase 0 latches the high byte.
  - Phase 1 drives pixel, asserts pixel_valid, and drives x = column and y = row; the column counter then increments.
  - Columns ≥ H_ACTIVE and rows ≥ V_ACTIVE: no pixel_valid. The line still counts toward the row counter.
  - On href=0:
    - The sampled byte is ignored.
    - Odd byte count: drop the partial byte and set line_error. Column count ≠ H_ACTIVE also sets line_error.
    - If the line produced ≥1 byte, the row counter increments (saturating at 2^Y_WIDTH-1).
    - Clear the column counter and phase, then go to LINE_WAIT.
  - vsync=1: abort the line with the same line checks. Row count including this line ≠ V_ACTIVE sets frame_error. Pulse frame_end, toggle parity, go to SYNC.
- Simultaneous href=1 and vsync=1: vsync wins; href is ignored.
- Counters never wrap into the valid range. The column counter saturates at H_ACTIVE.

## Timing
- **Pixel latency:** the second byte is sampled at edge k. pixel, pixel_valid, x and y are updated at edge k and visible in cycle k+1. pixel_valid is high for exactly one cycle.
- **Pixel rate:** maximum throughput is one pixel per two clocks. pixel and x/y hold their values between strobes.
- **Frame pulses:** frame_start and frame_end are registered at the edge where the vsync level change is sampled, and are high for one cycle. frame_parity and frame_error update on the same edge as frame_end.
- **Line error:** line_error updates on the edge where href=0 (or the aborting vsync=1) is sampled.
- **Gaps:** zero-cycle gaps are legal. href may fall and rise on consecutive edges, and vsync may rise on the edge after href falls.
- **Reset:** takes effect immediately and asynchronously. The first legal frame_start needs a full vsync high→low sequence after reset release.

## Structure
- Shared package `cam_pkg`:
  - state enum (HUNT, SYNC, LINE_WAIT, ACTIVE);
  - default H_ACTIVE/V_ACTIVE constants;
  - the byte-order constant (MSB first).
- One sub-module is natural: `byte_packer`. It holds the phase bit, the high-byte register and the 16-bit output register with valid strobe. It takes clk, reset, a clear input and an enable input.
- The FSM, counters and error logic stay in the top level.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3.
- **Clean frame:** reset; vsync 1 for 3 cycles, then 0; 3 lines of 8 bytes 0x00..0x07. Expect:
  - frame_start 1 cycle after vsync falls;
  - 12 pixel_valid strobes, pixels 0x0001, 0x0203, 0x0405, 0x0607 per line, x 0..3, y 0..2;
  - vsync high gives frame_end, parity=1, no errors.
- **Odd-length line:** a 7-byte line. Expect 3 pixels on that line, line_error=1 after href falls, next line y increments normally.
- **Short frame:** 2 lines, then vsync. Expect frame_end, frame_error=1, line_error=0.
- **Long line and long frame:** a 10-byte line, then 4 lines. Expect only x 0..3 strobed, no strobe on line 4, line_error=1, frame_error=1.
- **Mid-line vsync:** vsync rises after 3 bytes of line 1. Expect:
  - the partial pixel is dropped, line_error=1;
  - frame_end on the same edge, frame_error=1;
  - the next frame decodes cleanly from y=0.
- **Reset mid-frame:** assert reset during line 1. Expect all outputs 0 immediately. href bursts with vsync low produce no strobes until a vsync high→low sequence, then frame_start.
